// File: rtl/demux_scan_pkg.sv
// Shared types for the scanning LED demultiplexer.
package demux_scan_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_BLINK  = 2'b01,
        MODE_CHASE  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/demux_scan_prescaler.sv
// Free-running power-of-two prescaler: one-cycle wrap pulse plus a 50% phase bit.
module scan_prescaler #(
    parameter int unsigned DIV_W = 21
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick,
    output logic phase
);

    // Count value one below the wrap; tick is registered so it is high while div_cnt is all ones.
    localparam logic [DIV_W-1:0] PRE_WRAP = ~DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= (div_cnt == PRE_WRAP);
        end
    end

    assign phase = div_cnt[DIV_W-1];

endmodule

// File: rtl/demux_scan.sv
// Registered 1-of-N demux with latched address and autonomous blink/chase/bounce scanning.
module demux_scan
    import demux_scan_pkg::*;
#(
    parameter  int unsigned CHANNELS = 7,
    parameter  int unsigned DIV_W    = 21,
    localparam int unsigned ADDR_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                signal,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                addr_load,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] out,
    output logic [ADDR_W-1:0]   cur_addr,
    output logic                tick
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CHANNELS - 1);

    logic                phase;
    logic                dir;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                dir_nxt;
    logic [CHANNELS-1:0] out_nxt;
    logic [CHANNELS-1:0] onehot;
    logic                load_ok;
    mode_t               md;

    scan_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tick  (tick),
        .phase (phase)
    );

    // Next address/direction: a valid load beats a scan step.
    always_comb begin
        addr_nxt = cur_addr;
        dir_nxt  = dir;
        md       = mode_t'(mode);
        load_ok  = addr_load && (32'(addr) < CHANNELS);
        if (load_ok) begin
            addr_nxt = addr;
        end else if (tick && (CHANNELS > 1)) begin
            case (md)
                MODE_CHASE: begin
                    addr_nxt = (cur_addr == LAST) ? '0 : cur_addr + ADDR_W'(1);
                end
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        if (cur_addr == LAST) begin
                            addr_nxt = LAST - ADDR_W'(1);
                            dir_nxt  = DIR_DOWN;
                        end else begin
                            addr_nxt = cur_addr + ADDR_W'(1);
                        end
                    end else begin
                        if (cur_addr == '0) begin
                            addr_nxt = ADDR_W'(1);
                            dir_nxt  = DIR_UP;
                        end else begin
                            addr_nxt = cur_addr - ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from the pre-edge address, so out trails cur_addr by a cycle.
    always_comb begin
        onehot  = CHANNELS'(1) << cur_addr;
        out_nxt = onehot;
        case (md)
            MODE_PASS:  out_nxt = signal ? onehot : '0;
            MODE_BLINK: out_nxt = phase  ? onehot : '0;
            default:    out_nxt = onehot;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur_addr <= '0;
            dir      <= DIR_UP;
            out      <= '0;
        end else begin
            cur_addr <= addr_nxt;
            dir      <= dir_nxt;
            out      <= out_nxt;
        end
    end

endmodule

// File: tb/tb_demux_scan.sv
// Randomised bench for demux_scan (7 channels and 1 channel) against a cycle model.
module tb_demux_scan;

    localparam int DIV_W = 3;
    localparam int PER   = 1 << DIV_W;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       signal = 1'b0;
    logic [2:0] addr = '0;
    logic       addr_load = 1'b0;
    logic [1:0] mode = '0;

    logic [6:0] out7;
    logic [2:0] addr7;
    logic       tick7;
    logic [0:0] out1;
    logic [0:0] addr1;
    logic       tick1;

    int n_cmp = 0;
    int n_bad = 0;
    int hi6 = 0;

    always #5 CLK = ~CLK;

    demux_scan #(.CHANNELS(7), .DIV_W(DIV_W)) u_dut7 (
        .CLK(CLK), .RST_N(RST_N), .signal(signal), .addr(addr),
        .addr_load(addr_load), .mode(mode), .out(out7), .cur_addr(addr7), .tick(tick7)
    );

    demux_scan #(.CHANNELS(1), .DIV_W(DIV_W)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .signal(signal), .addr(addr[0]),
        .addr_load(addr_load), .mode(mode), .out(out1), .cur_addr(addr1), .tick(tick1)
    );

    // Model state: cycles since reset modulo the prescale period, selected channel, direction, output word.
    typedef struct {
        int cnt;
        int sel;
        bit down;
        int outv;
    } mst_t;

    mst_t m7 = '{cnt: 0, sel: 0, down: 1'b0, outv: 0};
    mst_t m1 = '{cnt: 0, sel: 0, down: 1'b0, outv: 0};

    function automatic mst_t mstep(int ch, mst_t s, int md, bit sig, int a, bit ld);
        mst_t n = s;
        bit tk = (s.cnt == PER - 1);
        bit ph = (s.cnt >= PER / 2);
        n.cnt = (s.cnt + 1) % PER;
        case (md)
            0:       n.outv = sig ? (1 << s.sel) : 0;
            1:       n.outv = ph ? (1 << s.sel) : 0;
            default: n.outv = 1 << s.sel;
        endcase
        if (ld && a < ch) begin
            n.sel = a;
        end else if (tk && ch > 1) begin
            if (md == 2) begin
                n.sel = (s.sel + 1) % ch;
            end else if (md == 3) begin
                if (!s.down && s.sel == ch - 1) begin
                    n.sel = ch - 2; n.down = 1'b1;
                end else if (s.down && s.sel == 0) begin
                    n.sel = 1; n.down = 1'b0;
                end else begin
                    n.sel = s.down ? s.sel - 1 : s.sel + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m7 <= '{cnt: 0, sel: 0, down: 1'b0, outv: 0};
            m1 <= '{cnt: 0, sel: 0, down: 1'b0, outv: 0};
        end else begin
            m7 <= mstep(7, m7, int'(mode), signal, int'(addr), addr_load);
            m1 <= mstep(1, m1, int'(mode), signal, int'(addr[0]), addr_load);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("out7", 32'(out7), 32'(m7.outv));
        chk("cur_addr7", 32'(addr7), 32'(m7.sel));
        chk("tick7", 32'(tick7), 32'(m7.cnt == PER - 1));
        chk("out1", 32'(out1), 32'(m1.outv));
        chk("cur_addr1", 32'(addr1), 32'(m1.sel));
        chk("tick1", 32'(tick1), 32'(m1.cnt == PER - 1));
    endtask

    // One clock: model check on the falling edge, then return just after the rising edge.
    task automatic cyc();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        #1;
        if (out7[6]) hi6++;
    endtask

    task automatic load(input int a);
        addr = 3'(a); addr_load = 1'b1;
        cyc();
        addr_load = 1'b0;
    endtask

    task automatic wait_change(input int budget, output int val, output int took);
        logic [2:0] prev = addr7;
        val = -1; took = 0;
        while (took < budget) begin
            cyc();
            took++;
            if (addr7 != prev) begin
                val = int'(addr7);
                return;
            end
        end
    endtask

    int v, t, tr;
    int chase_exp[4]  = '{6, 0, 1, 2};
    int bounce_exp[8] = '{6, 5, 4, 3, 2, 1, 0, 1};
    logic prev3;

    initial begin
        // Reset and PASS routing
        repeat (3) cyc();
        chk("reset_out", 32'(out7), 32'd0);
        chk("reset_addr", 32'(addr7), 32'd0);
        RST_N = 1'b1;
        signal = 1'b1;
        load(4);
        chk("pass_addr", 32'(addr7), 32'd4);
        cyc();
        chk("pass_out", 32'(out7), 32'b0010000);
        signal = 1'b0;
        cyc();
        chk("pass_drop", 32'(out7), 32'd0);

        // Out-of-range load is ignored
        load(7);
        chk("inv_addr", 32'(addr7), 32'd4);
        cyc();
        chk("inv_out", 32'(out7), 32'd0);

        // CHASE wraps 5 -> 6 -> 0 -> 1 -> 2, one tick period apart
        load(5);
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            wait_change(3 * PER, v, t);
            chk("chase_seq", 32'(v), 32'(chase_exp[i]));
            if (i > 0) chk("chase_gap", 32'(t), 32'(PER));
        end

        // BOUNCE turns around at both ends
        mode = 2'b00;
        load(5);
        mode = 2'b11;
        hi6 = 0;
        for (int i = 0; i < 8; i++) begin
            wait_change(3 * PER, v, t);
            chk("bounce_seq", 32'(v), 32'(bounce_exp[i]));
        end
        chk("bounce_hi6", 32'(hi6), 32'(PER));
        chk("ch1_bounce_addr", 32'(addr1), 32'd0);
        chk("ch1_bounce_out", 32'(out1), 32'd1);

        // Load colliding with a tick in CHASE
        mode = 2'b10;
        t = 0;
        while (!tick7 && t < 3 * PER) begin cyc(); t++; end
        chk("collide_tick_seen", 32'(tick7), 32'd1);
        load(2);
        chk("collide_addr", 32'(addr7), 32'd2);
        wait_change(3 * PER, v, t);
        chk("collide_next", 32'(v), 32'd3);

        // BLINK toggles every half period; async reset clears at once
        mode = 2'b00;
        load(3);
        mode = 2'b01;
        repeat (2) cyc();
        prev3 = out7[3];
        tr = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            if (out7[3] != prev3) tr++;
            prev3 = out7[3];
        end
        chk("blink_toggles", 32'(tr), 32'd4);
        t = 0;
        while (!out7[3] && t < 2 * PER) begin cyc(); t++; end
        chk("blink_high", 32'(out7[3]), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_out", 32'(out7), 32'd0);
        chk("async_addr", 32'(addr7), 32'd0);
        chk("async_tick", 32'(tick7), 32'd0);
        cyc();
        RST_N = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            signal    = 1'($urandom_range(0, 1));
            addr      = 3'($urandom_range(0, 7));
            addr_load = ($urandom_range(0, 15) == 0);
            RST_N     = ($urandom_range(0, 699) != 0);
            cyc();
        end
        RST_N = 1'b1;
        addr_load = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
